// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe: pipelined Wallace 3:2 compressor tree summing NOPS unsigned operands.
// Define CSA_TREE_CS_OUT_EN to drop the final adder and expose out_s/out_c.
module csa_tree_pipe #(
  parameter  int NN   = 16,
  parameter  int NOPS = 4,
  localparam int OW   = NN + $clog2(NOPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NOPS*NN-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
`ifdef CSA_TREE_CS_OUT_EN
  output logic [OW-1:0]      out_s,
  output logic [OW-1:0]      out_c,
`else
  output logic [OW-1:0]      out_sum,
`endif
  output logic               out_valid,
  input  logic               out_ready
);

  function automatic int nrows(input int l);
    int r;
    r = NOPS;
    for (int i = 0; i < l; i++)
      r = 2 * (r / 3) + r % 3;
    return r;
  endfunction

  function automatic int nlayers();
    int r;
    int n;
    r = NOPS;
    n = 0;
    for (int i = 0; i < 8; i++)
      if (r > 2) begin
        r = 2 * (r / 3) + r % 3;
        n++;
      end
    return n;
  endfunction

  localparam int NL = nlayers();

  typedef logic [OW-1:0] row_t;

  row_t        lin [NOPS];
  row_t        src [NOPS];
  row_t        nx  [1:NL][NOPS];
  row_t        st  [1:NL][NOPS];
  logic [NL:1] vld;
  logic        stall;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  always_comb
    for (int k = 0; k < NOPS; k++)
      lin[k] = {{(OW-NN){1'b0}}, in_data[k*NN +: NN]};

  // Layer l compresses the registered rows of layer l-1 (or the inputs).
  always_comb begin
    int   r;
    int   g;
    row_t a;
    row_t b;
    row_t c;
    r = 0;
    g = 0;
    a = '0;
    b = '0;
    c = '0;
    src = lin;
    for (int l = 1; l <= NL; l++)
      for (int k = 0; k < NOPS; k++)
        nx[l][k] = '0;
    for (int l = 1; l <= NL; l++) begin
      r = nrows(l - 1);
      g = r / 3;
      for (int k = 0; k < NOPS / 3; k++)
        if (k < g) begin
          a = src[3*k];
          b = src[3*k+1];
          c = src[3*k+2];
          nx[l][2*k]   = a ^ b ^ c;
          nx[l][2*k+1] = ((a & b) | (a & c) | (b & c)) << 1;
        end
      for (int j = 0; j < 2; j++)
        if (j < r % 3)
          nx[l][2*g+j] = src[3*g+j];
      src = st[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld <= '0;
      for (int l = 1; l <= NL; l++)
        for (int k = 0; k < NOPS; k++)
          st[l][k] <= '0;
    end else if (!stall) begin
      vld[1] <= in_valid;
      for (int l = 2; l <= NL; l++)
        vld[l] <= vld[l-1];
      st <= nx;
    end

`ifdef CSA_TREE_CS_OUT_EN
  assign out_s     = st[NL][0];
  assign out_c     = st[NL][1];
  assign out_valid = vld[NL];
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_sum   <= st[NL][0] + st[NL][1];
      out_valid <= vld[NL];
    end
`endif

endmodule
